mac_accumulator: RTL and testbench

Sequential multiply-accumulate stage built around the team's existing combinational 8x8 `mult` unit (a, b -> 16-bit y), which it instantiates. It accepts a block of LEN operand pairs over a valid/ready stream, registers each pair into `mult`, and sums the 16-bit products into an accumulator. The finished dot-product is presented on a valid/ready output. It sits between the operand source and whatever consumes the final sum.

---
 rtl/mac_accumulator.sv | 120 ++++++++++++
 tb/tb_mac_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// ============================================================================
// mac_accumulator : block multiply-accumulate over a valid/ready operand stream
// Rev 1.0
// ============================================================================
`default_nettype none

module mult (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] y
);
  assign y = a * b;
endmodule

module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_count;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic               r_p_valid;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic [15:0]        w_prod;
  logic [ACC_W:0]     w_sum;
  logic [LEN_W-1:0]   w_count_nxt;
  logic               w_xfer;

  mult u_mult (
    .a (r_a),
    .b (r_b),
    .y (w_prod)
  );

  assign w_xfer      = (r_state == S_RUN) && in_valid;
  assign w_count_nxt = r_count + {{(LEN_W-1){1'b0}}, 1'b1};
  // Extra MSB captures the carry-out that feeds the sticky overflow flag.
  assign w_sum       = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, w_prod};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_count   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_p_valid <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_p_valid <= w_xfer;
      if (w_xfer) begin
        r_a     <= a;
        r_b     <= b;
        r_count <= w_count_nxt;
      end
      if (r_p_valid) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_len   <= len;
            r_state <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_xfer && (w_count_nxt == r_len))
            r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_RUN);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign acc_out   = r_acc;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ============================================================================
// tb_mac_accumulator : directed self-checking bench for mac_accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, overflow, busy;
  logic [23:0] acc_out;
  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [15:0] acc_out16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow), .busy(busy)
  );

  mac_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16),
    .overflow(overflow16), .busy(busy16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0; len = 8'd77;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    checks++; if (acc_out !== 24'd0)  begin errors++; $display("FAIL rst_acc got %0d exp 0", acc_out); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf got %0b exp 0", overflow); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_block();
    pulse_start(8'd4);
    in_valid = 1'b1; a = 8'd3; b = 8'd5;
    tick();
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got %0b exp 0", busy); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %0b exp 0", out_valid); end
    checks++; if (acc_out !== 24'd0)  begin errors++; $display("FAIL mid_rst_acc got %0d exp 0", acc_out); end
    #1 reset_n = 1'b1;
    tick();
    pulse_start(8'd1);
    in_valid = 1'b1; a = 8'd2; b = 8'd2;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || acc_out !== 24'd4)
      begin errors++; $display("FAIL post_rst_block got valid=%0b acc=%0d exp valid=1 acc=4", out_valid, acc_out); end
    release_result();
  endtask

  task automatic test_basic_dot();
    logic [7:0] va [3] = '{8'd1, 8'd3, 8'd255};
    logic [7:0] vb [3] = '{8'd2, 8'd4, 8'd255};
    int ready_cycles = 0;
    pulse_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      if (in_ready === 1'b1) ready_cycles++;
      in_valid = 1'b1; a = va[i]; b = vb[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL basic_drain got in_ready=%0b out_valid=%0b exp 0 0", in_ready, out_valid); end
    tick();
    checks++; if (ready_cycles != 3) begin errors++; $display("FAIL basic_ready_cycles got %0d exp 3", ready_cycles); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b exp 1", out_valid); end
    checks++; if (acc_out !== 24'd65039) begin errors++; $display("FAIL basic_acc got %0d exp 65039", acc_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b exp 0", overflow); end
    release_result();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || acc_out !== 24'd65039)
      begin errors++; $display("FAIL basic_idle got busy=%0b valid=%0b acc=%0d exp 0 0 65039", busy, out_valid, acc_out); end
  endtask

  task automatic test_stall_backpressure();
    pulse_start(8'd2);
    in_valid = 1'b1; a = 8'd10; b = 8'd10;
    tick();
    in_valid = 1'b0; a = 8'd99; b = 8'd99;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready cyc %0d got %0b exp 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b1; a = 8'd7; b = 8'd9;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || acc_out !== 24'd163)
        begin errors++; $display("FAIL bp_hold cyc %0d got valid=%0b acc=%0d exp 1 163", i, out_valid, acc_out); end
      tick();
    end
    release_result();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%0b exp 0", busy); end
  endtask

  task automatic test_len_zero();
    in_valid = 1'b1; a = 8'd50; b = 8'd50;
    pulse_start(8'd0);
    checks++; if (out_valid !== 1'b1 || acc_out !== 24'd0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL len0 got valid=%0b acc=%0d in_ready=%0b exp 1 0 0", out_valid, acc_out, in_ready); end
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_max_block();
    int unsigned exp24 = 255 * 65025;
    int unsigned exp16 = (255 * 65025) % 65536;
    pulse_start(8'd255);
    in_valid = 1'b1; a = 8'd255; b = 8'd255;
    for (int i = 0; i < 255; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || acc_out !== exp24[23:0] || overflow !== 1'b0)
      begin errors++; $display("FAIL max24 got valid=%0b acc=%0d ovf=%0b exp 1 %0d 0", out_valid, acc_out, overflow, exp24); end
    checks++; if (out_valid16 !== 1'b1 || acc_out16 !== exp16[15:0] || overflow16 !== 1'b1)
      begin errors++; $display("FAIL max16 got valid=%0b acc=%0d ovf=%0b exp 1 %0d 1", out_valid16, acc_out16, overflow16, exp16); end
    release_result();
  endtask

  task automatic test_ignored_start();
    pulse_start(8'd1);
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = 8'd9; b = 8'd9;
    tick();
    in_valid = 1'b0;
    tick();
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1 || acc_out !== 24'd81)
      begin errors++; $display("FAIL ign_start got valid=%0b acc=%0d exp 1 81", out_valid, acc_out); end
    release_result();
  endtask

  task automatic test_back_to_back_products();
    int unsigned pa, pb, exp;
    for (int i = 0; i < 256; i++) begin
      pa = i; pb = (i * 7 + 3) % 256;
      exp = pa * pb;
      pulse_start(8'd1);
      in_valid = 1'b1; a = pa[7:0]; b = pb[7:0];
      tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || acc_out !== exp[23:0])
        begin errors++; $display("FAIL prod %0d*%0d got valid=%0b acc=%0d exp %0d", pa, pb, out_valid, acc_out, exp); end
      release_result();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_reset_mid_block();
    test_basic_dot();
    test_stall_backpressure();
    test_len_zero();
    test_max_block();
    test_ignored_start();
    test_back_to_back_products();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
